// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
  typedef logic req_id_t;
  function automatic logic [1:0] onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way winner select, one-hot grant.
// Round-robin tie break when DMEM_ARB_ROUND_ROBIN_EN is defined, fixed priority to requester 0 otherwise.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  always_comb grant = (&req_valid) ? onehot(!last_grant) : (req_valid[0] ? 2'b01 : {req_valid[1], 1'b0});
`else
  logic lg_unused;
  assign lg_unused = last_grant;
  always_comb grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and access sequencer for the single-port data memory.
// Optional round-robin tie break via DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);
  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
    $error("dmem_arbiter: MEM_LAT out of range");
  end
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);
  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  req_id_t           owner_q, owner_d;
  req_id_t           last_grant;
  logic [1:0]        gnt;
  logic              hs;
  req_id_t           win;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  req_id_t lg_q, lg_d;
  always_comb lg_d = hs ? win : lg_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lg_q <= 1'b1;
    else lg_q <= lg_d;
  assign last_grant = lg_q;
`else
  assign last_grant = 1'b1;
`endif
  rr_pick2 u_pick (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .grant     (gnt)
  );
  assign req_ready = (state_q == IDLE) ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign win       = gnt[1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = ACCESS;
        cnt_d   = LAT_M1;
        addr_d  = win ? req_addr1 : req_addr0;
        wdata_d = win ? req_wdata1 : req_wdata0;
        we_d    = req_we[win];
        owner_d = win;
      end
      ACCESS, WAIT: begin
        state_d = (cnt_q == '0) ? RESP : WAIT;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        rdata_d = (cnt_q == '0) ? (we_q ? '0 : mem_rdata) : rdata_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = (state_q == ACCESS || state_q == WAIT) && !we_q;
  assign mem_wr    = (state_q == ACCESS) && we_q;
  assign rsp_valid = (state_q == RESP) ? onehot(owner_q) : 2'b00;
  assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table-driven bench; u1 runs MEM_LAT=1, u3 runs MEM_LAT=3.
module tb_dmem_arbiter;
  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [15:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_wr;
  logic [1:0]  req_valid3, req_ready3, req_we3, rsp_valid3;
  logic [15:0] req_addr03, req_addr13, req_wdata03, req_wdata13;
  logic [15:0] rsp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        mem_re3, mem_wr3;
  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_wr(mem_wr), .mem_rdata(mem_rdata));

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_addr0(req_addr03), .req_addr1(req_addr13), .req_wdata0(req_wdata03), .req_wdata1(req_wdata13),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_re(mem_re3), .mem_wr(mem_wr3), .mem_rdata(mem_rdata3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr[7:0]];
  assign mem_rdata3 = mem[mem_addr3[7:0]];
  always @(posedge clk)
    if (!rst_n) begin
      mem[8'h01] <= 16'h0008;
      mem[8'h20] <= 16'h1111;
      mem[8'h21] <= 16'h2222;
    end else begin
      if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_wr3) mem[mem_addr3[7:0]] <= mem_wdata3;
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v, we;
    logic [15:0] a0, a1, d0, d1;
    logic [1:0]  gnt;
    logic [15:0] addr, wdata, rdata;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cyc[$];
    logic [1:0] t0, t1;
    tbl[0] = '{2'b01, 2'b00, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 2'b01, 16'h0001, 16'h0000, 16'h0008};
    tbl[1] = '{2'b10, 2'b10, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 2'b10, 16'h0010, 16'hBEEF, 16'h0000};
    tbl[2] = '{2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[3] = '{2'b10, 2'b00, 16'h0000, 16'h0021, 16'h0000, 16'h0000, 2'b10, 16'h0021, 16'h0000, 16'h2222};
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    t0 = 2'b01; t1 = 2'b10;
`else
    t0 = 2'b01; t1 = 2'b01;
`endif
    for (int i = 4; i < 8; i++)
      tbl[i] = '{2'b11, 2'b00, 16'h0020, 16'h0021, 16'h0A0A, 16'h0B0B, (i % 2 == 0) ? t0 : t1,
                 ((i % 2 == 0) ? t0 : t1) == 2'b01 ? 16'h0020 : 16'h0021,
                 ((i % 2 == 0) ? t0 : t1) == 2'b01 ? 16'h0A0A : 16'h0B0B,
                 ((i % 2 == 0) ? t0 : t1) == 2'b01 ? 16'h1111 : 16'h2222};
    tbl[8] = '{2'b11, 2'b11, 16'h0030, 16'h0031, 16'h1234, 16'h5678, 2'b01, 16'h0030, 16'h1234, 16'h0000};
    tbl[9] = '{2'b01, 2'b00, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 2'b01, 16'h0030, 16'h0000, 16'h1234};

    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    req_valid3 = '0; req_we3 = '0; req_addr03 = '0; req_addr13 = '0; req_wdata03 = '0; req_wdata13 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", {req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_re, mem_wr}, '0);
    chk("rst_outs3", {req_ready3, rsp_valid3, rsp_rdata3, mem_addr3, mem_re3, mem_wr3}, '0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      req_valid = tbl[i].v; req_we = tbl[i].we;
      req_addr0 = tbl[i].a0; req_addr1 = tbl[i].a1; req_wdata0 = tbl[i].d0; req_wdata1 = tbl[i].d1;
      #1 chk($sformatf("v%0d_ready", i), req_ready, tbl[i].gnt);
      @(negedge clk);
      req_valid = '0; req_addr0 = 16'hFFFF; req_addr1 = 16'hFFFF; req_wdata0 = 16'hDEAD; req_wdata1 = 16'hDEAD;
      #1;
      chk($sformatf("v%0d_ready_c1", i), req_ready, 2'b00);
      chk($sformatf("v%0d_re", i), mem_re, !(|(tbl[i].we & tbl[i].gnt)));
      chk($sformatf("v%0d_wr", i), mem_wr, |(tbl[i].we & tbl[i].gnt));
      chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wdata);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tbl[i].gnt);
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, tbl[i].rdata);
      chk($sformatf("v%0d_strobes_resp", i), {mem_re, mem_wr}, 2'b00);
    end

    // MEM_LAT=3 read on u3: strobe cycles 1-3, response in cycle 4
    @(negedge clk);
    req_valid3 = 2'b01; req_addr03 = 16'h0020;
    #1 chk("l3_ready_c0", req_ready3, 2'b01);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("l3_re_c%0d", c), {mem_re3, mem_wr3}, 2'b10);
      chk($sformatf("l3_addr_c%0d", c), mem_addr3, 16'h0020);
      chk($sformatf("l3_ready_c%0d", c), req_ready3, 2'b00);
      chk($sformatf("l3_rsp_c%0d", c), rsp_valid3, 2'b00);
    end
    @(negedge clk);
    #1;
    chk("l3_rsp_valid", rsp_valid3, 2'b01);
    chk("l3_rsp_rdata", rsp_rdata3, 16'h1111);
    chk("l3_ready_c4", req_ready3, 2'b00);
    chk("l3_re_c4", mem_re3, 1'b0);
    req_valid3 = '0;

    // reset pulse while u3 is in WAIT
    @(negedge clk);
    req_valid3 = 2'b10; req_addr13 = 16'h0020;
    #1 chk("rw_ready", req_ready3, 2'b10);
    @(negedge clk);
    req_valid3 = '0;
    @(negedge clk);
    #1 chk("rw_in_wait", mem_re3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_async3", {req_ready3, rsp_valid3, rsp_rdata3, mem_addr3, mem_wdata3, mem_re3, mem_wr3}, '0);
    chk("rw_async1", {rsp_rdata, mem_addr, mem_wdata}, '0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk($sformatf("rw_no_rsp_%0d", c), rsp_valid3, 2'b00);
    end
    @(negedge clk);
    req_valid3 = 2'b01; req_addr03 = 16'h0021;
    #1 chk("rw_regrant", req_ready3, 2'b01);
    @(negedge clk);
    req_valid3 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rw_rsp_valid", rsp_valid3, 2'b01);
    chk("rw_rsp_rdata", rsp_rdata3, 16'h2222);

    // back-to-back requester 0 on u1: handshakes every MEM_LAT+2 = 3 cycles
    @(negedge clk);
    req_valid = 2'b01; req_we = '0; req_addr0 = 16'h0001;
    for (int c = 0; c < 20; c++) begin
      #1 if (req_ready[0]) hs_cyc.push_back(c);
      @(negedge clk);
    end
    req_valid = '0;
    chk("b2b_count", hs_cyc.size() >= 5, 1);
    for (int k = 1; k < 5 && k < hs_cyc.size(); k++)
      chk($sformatf("b2b_gap%0d", k), hs_cyc[k] - hs_cyc[k-1], 3);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the 16-bit data memory. It shares the memory's single port (`address`/`data_in`/`data_out`/`re`/`wr`) between the load/store unit (requester 0) and the debug/DMA port (requester 1). It serialises accesses, drives the memory strobes for the configured access latency, and returns read data or a write acknowledge to the requester that owns the transaction. It sits between the execute stage and the data memory.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 1, cycles from strobe assertion to `mem_rdata` valid; legal range 1–7

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid[1:0]` in 2: request valid, bit i = requester i
- `req_ready[1:0]` out 2: request accepted this cycle; one-hot or zero
- `req_we[1:0]` in 2: 1 = write, 0 = read
- `req_addr0`, `req_addr1` in ADDR_W: request address
- `req_wdata0`, `req_wdata1` in DATA_W: write data
- `rsp_valid[1:0]` out 2: one-cycle response pulse to the owning requester
- `rsp_rdata` out DATA_W: read data, shared; qualified by `rsp_valid`
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: to memory
- `mem_re` out 1, `mem_wr` out 1: memory strobes
- `mem_rdata` in DATA_W: from memory

## Operation
- FSM states: IDLE → ACCESS → (WAIT) → RESP → IDLE. Only one transaction is outstanding at a time.
- IDLE:
  - If any `req_valid` is set, `req_ready` is asserted combinationally for the winner.
  - The handshake occurs when `req_valid & req_ready`.
  - On the handshake, the arbiter latches addr, wdata, we and owner id, loads the latency counter with `MEM_LAT-1`, and goes to ACCESS.
- ACCESS:
  - `mem_addr` and `mem_wdata` are driven from the latched values.
  - `mem_re` = !we; `mem_wr` = we. `mem_wr` is high for exactly this one cycle.
  - If the counter is 0, go to RESP; otherwise go to WAIT.
- WAIT: `mem_re` and `mem_addr` are held; `mem_wr` = 0. The counter decrements each cycle; go to RESP when it reaches 0.
- Read data: `mem_rdata` is sampled into `rsp_rdata` on the edge that leaves the last ACCESS/WAIT cycle. For writes, `rsp_rdata` is loaded with 0.
- RESP: `rsp_valid[owner]` = 1 for one cycle, all strobes are 0, and the next state is IDLE. No new grant is issued in RESP.
- `req_ready` is 0 in every state except IDLE.
- Arbitration: simultaneous requests are resolved per Configuration. A lone requester always wins.
- Requester payload may change once its `req_ready` handshake is done; it is ignored afterwards.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0
  - `mem_re` = 0, `mem_wr` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - `last_grant` = 1
- Latency: with the handshake in cycle 0, ACCESS is cycle 1, WAIT covers cycles 2..MEM_LAT, and `rsp_valid` is high in cycle MEM_LAT+1.
- Throughput: one transaction per MEM_LAT+2 cycles. The next handshake can occur in cycle MEM_LAT+2.
- Reset asserted mid-transaction: the arbiter returns to IDLE immediately and all outputs drop to their reset values asynchronously. The in-flight transaction is dropped with no response; a write already strobed is not undone.
- `req_valid` deasserted before its handshake: no grant is issued and no state change occurs.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, the requester that is not `last_grant` wins.
  - `last_grant` is updated on every handshake; its reset value is 1, so requester 0 wins the first tie.
- Not defined:
  - Fixed priority: requester 0 always wins a tie; requester 1 can starve.
  - The `last_grant` register is not built.

## Structure
- Package `dmem_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, ACCESS, WAIT, RESP}
  - `req_id_t` (1-bit owner id)
  - default `ADDR_W`/`DATA_W` constants
  - `MEM_LAT_MAX` = 7
- Sub-module `rr_pick2`: a combinational 2-way winner select taking `req_valid` and `last_grant`. It honours `DMEM_ARB_ROUND_ROBIN_EN` and outputs a one-hot grant.
- The top level holds the FSM, latency counter, payload latches and the response register.

## Test plan
- MEM_LAT=1, rst_n released, requester 0 reads addr 0x0001 with memory word 0x0008 → `req_ready[0]` in cycle 0; `mem_re`=1 with `mem_addr`=0x0001 in cycle 1; `rsp_valid[0]`=1 with `rsp_rdata`=0x0008 in cycle 2.
- Requester 1 writes 0xBEEF to 0x0010 → `mem_wr` is high for exactly one cycle with `mem_wdata`=0xBEEF; `rsp_valid[1]` pulses with `rsp_rdata`=0; a following read of 0x0010 returns 0xBEEF.
- Both requesters hold `req_valid` for 4 transactions, macro defined → grants go 0,1,0,1. Macro undefined → grants go 0,0,0,0.
- MEM_LAT=3 read → `mem_re` is held for cycles 1–3 and `rsp_valid` appears in cycle 4; `req_ready` stays 0 in cycles 1–4.
- `rst_n` pulsed low during WAIT → all outputs go to 0 immediately, no `rsp_valid` is issued, and the next request is granted normally after release.
- Back-to-back requests from requester 0 → handshakes are spaced exactly MEM_LAT+2 cycles apart.
